// File: rtl/taskb.sv
// ---------------------------------------------------------------------------
// taskb -- push-button synchronizer, debouncer and press-strobe generator.
//
// The raw button level is brought into the CLK domain through a chain of
// SYNC_STAGES flops. The synchronized level must then disagree with the
// accepted (debounced) level for DEBOUNCE_CYCLES consecutive edges before it
// is accepted. Every accepted 0->1 transition of the debounced level yields
// one registered, single-cycle strobe on pulse.
//
// Parameters
//   SYNC_STAGES      synchronizer depth on button (2..4)
//   DEBOUNCE_CYCLES  consecutive edges a changed level must persist (1..65535)
//
// Ports
//   CLK     in   single clock, rising edge
//   RST_N   in   asynchronous assert, active-low reset
//   button  in   raw asynchronous push-button level, 1 = pressed
//   pulse   out  one-cycle strobe per accepted press
// ---------------------------------------------------------------------------
module taskb #(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 2
) (
   input  logic CLK,
   input  logic RST_N,
   input  logic button,
   output logic pulse
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW:0] DEB_TARGET = DEBOUNCE_CYCLES[CW:0];

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   sync_out;
   logic                   stable;
   logic [CW-1:0]          cnt;
   logic [CW:0]            cnt_inc;
   logic                   differ;
   logic                   accept;

   // Synchronizer: sync_q[0] samples the raw pin, the top bit is sync_out.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], button};
      end
   end

   assign sync_out = sync_q[SYNC_STAGES-1];

   // One extra bit on the increment so the comparison against the target
   // cannot alias when DEBOUNCE_CYCLES fills the counter width exactly.
   assign differ  = (sync_out != stable);
   assign cnt_inc = {1'b0, cnt} + 1'b1;
   assign accept  = differ && (cnt_inc == DEB_TARGET);

   // Debounce: any edge agreeing with stable restarts the count, so a glitch
   // shorter than DEBOUNCE_CYCLES never reaches acceptance. The counter is
   // cleared on acceptance and therefore never exceeds DEBOUNCE_CYCLES-1.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         stable <= 1'b0;
         cnt    <= '0;
      end else if (!differ) begin
         cnt <= '0;
      end else if (accept) begin
         stable <= sync_out;
         cnt    <= '0;
      end else begin
         cnt <= cnt_inc[CW-1:0];
      end
   end

   // Strobe on the same edge stable is loaded with 1; releases give nothing.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         pulse <= 1'b0;
      end else begin
         pulse <= accept & sync_out;
      end
   end

endmodule

// File: tb/tb_taskb.sv
// ---------------------------------------------------------------------------
// tb_taskb -- self-checking bench for taskb.
//
// Four instances share clock, reset and button: (sync,debounce) =
// (2,2) defaults, (2,1), (2,5) and (4,3). Each instance has its own reference
// model that keeps the full history of button samples, derives the
// synchronized level as the sample taken SYNC edges earlier, and accepts a
// new level when the last DEBOUNCE synchronized samples all disagree with
// the accepted level. Model pulse is compared with the DUT on every falling
// edge; directed sections additionally check latencies and pulse counts.
// ---------------------------------------------------------------------------
module tb_taskb;

   localparam int NI = 4;

   logic          clk;
   logic          rst_n;
   logic          button;
   logic [NI-1:0] pulse_v;
   int            pcnt [NI];

   int nchk;
   int nfail;

   initial clk = 1'b0;
   always #10 clk = ~clk;

   task automatic check(input string tag, input int act, input int exp);
      nchk++;
      if (act != exp) begin
         nfail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
      end
   endtask

   function automatic int sync_of(input int i);
      return (i == 3) ? 4 : 2;
   endfunction

   function automatic int deb_of(input int i);
      case (i)
         0:       return 2;
         1:       return 1;
         2:       return 5;
         default: return 3;
      endcase
   endfunction

   for (genvar gi = 0; gi < NI; gi++) begin : g_inst
      localparam int S = sync_of(gi);
      localparam int D = deb_of(gi);
      logic p;

      taskb #(.SYNC_STAGES(S), .DEBOUNCE_CYCLES(D)) u_dut (
         .CLK   (clk),
         .RST_N (rst_n),
         .button(button),
         .pulse (p)
      );

      assign pulse_v[gi] = p;

      bit bs  [$];
      bit soh [$];
      bit stab;
      bit mp;
      int ne;

      always @(posedge clk or negedge rst_n) begin
         bit so;
         bit acc;
         if (!rst_n) begin
            bs.delete();
            soh.delete();
            stab = 1'b0;
            mp   = 1'b0;
            ne   = 0;
         end else begin
            so = (ne < S) ? 1'b0 : bs[ne-S];
            bs.push_back(button);
            soh.push_back(so);
            ne++;
            acc = (soh.size() >= D);
            for (int k = 0; k < D; k++)
               if (acc && soh[soh.size()-1-k] == stab) acc = 1'b0;
            mp = acc && so;
            if (acc) stab = so;
         end
      end

      always @(negedge clk) begin
         check($sformatf("model_pulse[%0d]", gi), int'(p), int'(mp));
         if (p) pcnt[gi]++;
      end
   end

   // Drive button high after a falling edge and report, per instance, the
   // 1-based index of the rising edge at which pulse was first seen high.
   task automatic press_latency(output int lat [NI]);
      for (int i = 0; i < NI; i++) lat[i] = 0;
      @(negedge clk);
      button = 1'b1;
      for (int e = 1; e <= 20; e++) begin
         @(posedge clk);
         #1;
         for (int i = 0; i < NI; i++)
            if (pulse_v[i] && lat[i] == 0) lat[i] = e;
      end
   endtask

   task automatic idle(input int n);
      @(negedge clk);
      button = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   initial begin
      int lat [NI];
      int base;
      int seen;

      nchk   = 0;
      nfail  = 0;
      button = 1'b0;
      rst_n  = 1'b0;
      for (int i = 0; i < NI; i++) pcnt[i] = 0;

      repeat (3) @(negedge clk);
      check("reset_pulse", int'(pulse_v), 0);
      rst_n = 1'b1;
      idle(10);
      check("idle_no_pulse", pcnt[0] + pcnt[1] + pcnt[2] + pcnt[3], 0);

      // Clean press: latency S+D, exactly one pulse while held.
      for (int i = 0; i < NI; i++) pcnt[i] = 0;
      press_latency(lat);
      for (int i = 0; i < NI; i++) begin
         check($sformatf("press_latency[%0d]", i), lat[i], sync_of(i) + deb_of(i));
         check($sformatf("press_count[%0d]", i), pcnt[i], 1);
      end
      idle(12);
      check("release_no_pulse", pcnt[0], 1);

      // One-cycle glitch on the default instance is rejected.
      base = pcnt[0];
      @(negedge clk) button = 1'b1;
      @(negedge clk) button = 1'b0;
      repeat (8) @(negedge clk);
      check("glitch_count", pcnt[0] - base, 0);
      check("glitch_stable", int'(g_inst[0].u_dut.stable), 0);
      idle(12);

      // Sub-cycle dip that no rising edge samples: one press only.
      base = pcnt[0];
      @(negedge clk) button = 1'b1;
      @(negedge clk);
      #2 button = 1'b0;
      #5 button = 1'b1;
      repeat (6) @(negedge clk);
      check("bounce_count", pcnt[0] - base, 1);
      idle(12);

      // Release and re-press: two pulses, none on release.
      base = pcnt[0];
      @(negedge clk) button = 1'b1;
      repeat (5) @(negedge clk);
      button = 1'b0;
      repeat (5) @(negedge clk);
      button = 1'b1;
      repeat (8) @(negedge clk);
      check("repress_count", pcnt[0] - base, 2);
      idle(12);

      // Reset while pulse is high: pulse drops at once, nothing afterwards.
      seen = 0;
      @(negedge clk) button = 1'b1;
      for (int e = 0; e < 20 && seen == 0; e++) begin
         @(posedge clk);
         #1;
         if (pulse_v[0]) seen = 1;
      end
      check("pulse_seen_before_reset", seen, 1);
      #2 rst_n = 1'b0;
      #1 check("reset_mid_pulse", int'(pulse_v[0]), 0);
      button = 1'b0;
      @(negedge clk) rst_n = 1'b1;
      base = pcnt[0];
      repeat (10) @(negedge clk);
      check("after_reset_no_pulse", pcnt[0] - base, 0);

      // Reset mid-count (default instance has cnt=1 after the third edge).
      @(negedge clk) button = 1'b1;
      repeat (3) @(posedge clk);
      #3 check("cnt_before_reset", int'(g_inst[0].u_dut.cnt), 1);
      rst_n = 1'b0;
      #1 check("reset_mid_count_cnt", int'(g_inst[0].u_dut.cnt), 0);
      check("reset_mid_count_pulse", int'(pulse_v), 0);
      button = 1'b0;
      @(negedge clk) rst_n = 1'b1;
      base = pcnt[0];
      repeat (10) @(negedge clk);
      check("after_count_reset_no_pulse", pcnt[0] - base, 0);

      // Button held through reset release is a new press.
      button = 1'b1;
      rst_n  = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < NI; i++) lat[i] = 0;
      for (int e = 1; e <= 20; e++) begin
         @(posedge clk);
         #1;
         if (pulse_v[0] && lat[0] == 0) lat[0] = e;
      end
      check("held_through_reset_latency", lat[0], 4);
      idle(12);

      // Random segments, some with sub-cycle dips; the models check each edge.
      for (int s = 0; s < 400; s++) begin
         @(negedge clk);
         button = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 5) == 0) begin
            #3 button = ~button;
            #4 button = ~button;
         end
         repeat ($urandom_range(0, 7)) @(negedge clk);
      end
      idle(12);

      $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
      $finish;
   end

endmodule

// File: doc/taskb.md
TASKB -- requirements
Module: taskb

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, number of synchronizer flops on button (legal range 2..4).
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 2, number of consecutive clock edges a changed level must persist before acceptance (legal range 1..65535).
REQ-003 SHALL have port CLK  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port RST_N  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port button  input  1  raw, asynchronous, possibly bouncing push-button level; 1 = pressed.
REQ-006 SHALL have port pulse  output  1  registered single-cycle strobe, one per accepted press.

Function
REQ-007 SHALL pass button through a chain of SYNC_STAGES flops; the last flop is sync_out.
REQ-008 SHALL hold a debounced level stable and a saturating counter cnt of width ceil(log2(DEBOUNCE_CYCLES+1)).
REQ-009 SHALL, on each edge where sync_out equals stable, clear cnt to 0.
REQ-010 SHALL, on each edge where sync_out differs from stable, increment cnt. When the incremented value equals DEBOUNCE_CYCLES, it SHALL load stable with sync_out and clear cnt on that same edge.
REQ-011 SHALL treat any return of sync_out to stable before acceptance as a glitch: cnt restarts from 0 and no change of stable occurs.
REQ-012 SHALL set pulse to 1 on exactly the edge where stable goes 0->1, and to 0 on every other edge; pulse width is exactly one CLK period.
REQ-013 SHALL produce no pulse on release (stable 1->0).
REQ-014 SHALL produce no further pulse while button stays held, however long.
REQ-015 SHALL give, with defaults, a press latency of 4 edges: if button is first sampled 1 at edge E0 and held, pulse is high from E3 to E4.
REQ-016 SHALL give a general press latency of SYNC_STAGES+DEBOUNCE_CYCLES edges, counting E0 as the first.
REQ-017 SHALL produce at most one pulse per DEBOUNCE_CYCLES+1 edges, and two pulses SHALL always be separated by an accepted release.
REQ-018 SHALL be free of combinational paths from button to pulse.

Reset
REQ-019 SHALL, while RST_N = 0, asynchronously force all synchronizer flops, stable, cnt and pulse to 0.
REQ-020 SHALL resume normal operation on the first CLK rising edge after RST_N returns to 1; RST_N deassertion is assumed synchronous to CLK.
REQ-021 SHALL, if RST_N asserts mid-pulse or mid-count, immediately drop pulse to 0 and discard the partial count.
REQ-022 SHALL, if button is held at 1 through reset release, emit one pulse 4 edges after release (defaults), treating the held button as a new press.

Verification
REQ-023 SHALL cover clean press: defaults, button 0->1 held 6 cycles -> exactly one pulse, high for 1 cycle, 4 edges after first sampled-high edge; pulse 0 otherwise.
REQ-024 SHALL cover glitch: button high for 1 cycle only, then 0 for 6 cycles -> pulse never asserts, stable stays 0.
REQ-025 SHALL cover bounce: button 1, then 0 for a sub-cycle dip (for example 5 ns in a 20 ns period), then 1 held 3+ cycles -> at most one pulse, single-cycle; no pulse on the dip.
REQ-026 SHALL cover release and re-press: press held 5 cycles, release held 5 cycles, press again -> exactly two pulses, none on release.
REQ-027 SHALL cover reset mid-operation: RST_N low while cnt = 1 or pulse = 1 -> pulse 0 immediately; after release with button 0, no pulse.
REQ-028 SHALL cover parameter sweep: DEBOUNCE_CYCLES = 1 and 5 -> press latency of 3 and 7 edges respectively.
